mem_port_arbiter: RTL

Sequences the single unified instruction/data memory of the multicycle CPU and shares it between two requesters. The instruction-fetch port (i_*) and the load/store port (d_*) are driven by the control unit. The block arbitrates between them, inserts the memory's fixed read-latency wait states, and returns a one-cycle done pulse with registered read data. This replaces hard-coded delay states in the control FSM with a req/done handshake.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified instruction/data memory between the fetch (i_*) and load/store (d_*) ports.
// Optional: define MEM_ARB_RR_EN for last-grant tie breaking instead of fixed D-over-I priority.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2,
    parameter int CNT_W    = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;   // 1 = D port, 0 = I port
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              pick_d;
`ifdef MEM_ARB_RR_EN
    logic              last_q, last_d;     // 1 = D was granted last
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d    = last_q;
        pick_d    = d_req && !(i_req && last_q);
`else
        pick_d    = d_req;
`endif

        case (state_q)
            IDLE: begin
                if (d_req || i_req) begin
                    grant_d = pick_d;
                    addr_d  = pick_d ? d_addr : i_addr;
                    we_d    = pick_d && d_we;
                    // Fetches carry no write data, so mem_wdata keeps the last store value.
                    if (pick_d) begin
                        wdata_d = d_wdata;
                    end
`ifdef MEM_ARB_RR_EN
                    last_d  = pick_d;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = CNT_W'(READ_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (grant_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        i_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    // Reset gates the strobe combinationally so an interrupted store never writes.
    assign mem_wr    = (state_q == ACCESS) && we_q && !Reset;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_done    = (state_q == DONE) && !grant_q;
    assign d_done    = (state_q == DONE) && grant_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule
